// File: rtl/uart_tx_cfg.sv
// UART transmitter fed from a show-ahead FIFO: start bit, SIZE_DATA data bits LSB first,
// optional parity (build with UART_TX_PARITY_EN), one or two stop bits, OVER_SAMPLE ticks per bit.
module uart_tx_cfg #(
    parameter int SIZE_DATA   = 8,
    parameter int OVER_SAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stick,
    input  logic                 i_tx_en,
    input  logic                 i_fifo_empty,
    input  logic [SIZE_DATA-1:0] i_tx_data,
    input  logic                 i_stop2,
    input  logic                 i_parity_en,
    input  logic                 i_parity_odd,
    output logic                 o_rd_en,
    output logic                 o_tx_serial,
    output logic                 o_tx_done,
    output logic                 o_valid
);

    localparam int CW = $clog2(OVER_SAMPLE);
    localparam int BW = $clog2(SIZE_DATA);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t               state, state_nx;
    logic [CW-1:0]        tick_cnt, tick_cnt_nx;
    logic [BW-1:0]        bit_idx, bit_idx_nx;
    logic                 second_stop, second_stop_nx;
    logic [SIZE_DATA-1:0] data_q;
    logic                 stop2_q;
    logic                 armed;
    logic                 bit_done;
    logic                 load;

`ifdef UART_TX_PARITY_EN
    logic par_en_q;
    logic par_bit_q;
`else
    logic unused_parity;
    assign unused_parity = i_parity_en ^ i_parity_odd;
`endif

    assign bit_done = i_stick && (tick_cnt == CW'(OVER_SAMPLE - 1));
    assign o_valid  = (state != IDLE);
    assign o_rd_en  = load;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_nx       = state;
        tick_cnt_nx    = tick_cnt;
        bit_idx_nx     = bit_idx;
        second_stop_nx = second_stop;
        o_tx_serial    = 1'b1;
        o_tx_done      = 1'b0;

        if (state != IDLE && i_stick)
            tick_cnt_nx = bit_done ? '0 : tick_cnt + 1'b1;

        case (state)
            IDLE: ;
            START: begin
                o_tx_serial = 1'b0;
                if (bit_done) begin
                    state_nx   = DATA;
                    bit_idx_nx = '0;
                end
            end
            DATA: begin
                o_tx_serial = data_q[bit_idx];
                if (bit_done) begin
                    if (bit_idx == BW'(SIZE_DATA - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_nx = par_en_q ? PARITY : STOP;
`else
                        state_nx = STOP;
`endif
                        second_stop_nx = 1'b0;
                    end else begin
                        bit_idx_nx = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                o_tx_serial = par_bit_q;
                if (bit_done) begin
                    state_nx       = STOP;
                    second_stop_nx = 1'b0;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    if (stop2_q && !second_stop) begin
                        second_stop_nx = 1'b1;
                    end else begin
                        o_tx_done = 1'b1;
                        state_nx  = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A new frame may start from IDLE or directly in the done cycle (back-to-back).
        load = armed && i_tx_en && !i_fifo_empty && (state == IDLE || o_tx_done);
        if (load) begin
            state_nx    = START;
            tick_cnt_nx = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            second_stop <= 1'b0;
            data_q      <= '0;
            stop2_q     <= 1'b0;
            armed       <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
`endif
        end else begin
            state       <= state_nx;
            tick_cnt    <= tick_cnt_nx;
            bit_idx     <= bit_idx_nx;
            second_stop <= second_stop_nx;
            // Blocks loading in the first cycle after reset release.
            armed       <= 1'b1;
            if (load) begin
                data_q    <= i_tx_data;
                stop2_q   <= i_stop2;
`ifdef UART_TX_PARITY_EN
                par_en_q  <= i_parity_en;
                par_bit_q <= (^i_tx_data) ^ i_parity_odd;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: a stick-counting frame model predicts every output
// each cycle; directed scenarios plus a randomized phase exercise the frame rules.
module tb_uart_tx_cfg;

    localparam int SD = 8;
    localparam int OS = 16;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR_BUILD = 1'b1;
`else
    localparam bit PAR_BUILD = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst_n;
    logic          i_stick;
    logic          i_tx_en;
    logic          i_fifo_empty;
    logic [SD-1:0] i_tx_data;
    logic          i_stop2;
    logic          i_parity_en;
    logic          i_parity_odd;
    logic          o_rd_en;
    logic          o_tx_serial;
    logic          o_tx_done;
    logic          o_valid;

    uart_tx_cfg #(.SIZE_DATA(SD), .OVER_SAMPLE(OS)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_stick      (i_stick),
        .i_tx_en      (i_tx_en),
        .i_fifo_empty (i_fifo_empty),
        .i_tx_data    (i_tx_data),
        .i_stop2      (i_stop2),
        .i_parity_en  (i_parity_en),
        .i_parity_odd (i_parity_odd),
        .o_rd_en      (o_rd_en),
        .o_tx_serial  (o_tx_serial),
        .o_tx_done    (o_tx_done),
        .o_valid      (o_valid)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [SD-1:0] fifo_q[$];
    bit            pop_pending = 1'b0;
    bit            stick_rand  = 1'b0;
    int            phase       = 0;

    // Reference model: a frame is a list of line levels, each held for OS sticks after load.
    bit          m_busy  = 1'b0;
    bit          m_armed = 1'b0;
    int          m_s     = 0;
    int          m_n     = 0;
    logic [15:0] m_bits  = '0;

    int cyc = 0, n_rd = 0, n_done = 0, last_done = 0, prev_done = 0;
    int stick_cnt = 0, sticks_at_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void build_frame(input logic [SD-1:0] d, input logic s2,
                                        input logic pe, input logic po);
        m_bits    = '1;
        m_bits[0] = 1'b0;
        for (int i = 0; i < SD; i++) m_bits[1+i] = d[i];
        m_n = 1 + SD;
        if (PAR_BUILD && pe) begin
            m_bits[m_n] = (^d) ^ po;
            m_n++;
        end
        m_n = m_n + (s2 ? 2 : 1);
    endfunction

    task automatic drive_fifo();
        i_fifo_empty = (fifo_q.size() == 0);
        i_tx_data    = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endtask

    task automatic drive_stick();
        if (stick_rand) begin
            i_stick = ($urandom_range(2) == 0);
        end else begin
            phase   = (phase + 1) % 4;
            i_stick = (phase == 0);
        end
    endtask

    // Called mid-cycle: predict this cycle's outputs, compare, then advance the model.
    task automatic eval();
        logic e_ser, e_val, e_rd, e_done;
        if (!i_rst_n) begin
            m_busy  = 1'b0;
            m_armed = 1'b0;
        end
        e_ser  = 1'b1;
        e_val  = 1'b0;
        e_done = 1'b0;
        if (m_busy) begin
            e_val  = 1'b1;
            e_ser  = m_bits[m_s / OS];
            e_done = i_stick && (m_s == OS * m_n - 1);
        end
        e_rd = i_rst_n && m_armed && i_tx_en && !i_fifo_empty && (!m_busy || e_done);
        check("serial", o_tx_serial, e_ser);
        check("valid",  o_valid,     e_val);
        check("rd_en",  o_rd_en,     e_rd);
        check("done",   o_tx_done,   e_done);

        cyc++;
        if (i_stick) stick_cnt++;
        if (o_tx_done) begin
            n_done++;
            prev_done      = last_done;
            last_done      = cyc;
            sticks_at_done = stick_cnt;
        end
        if (o_rd_en) begin
            n_rd++;
            stick_cnt = 0;
        end
        pop_pending = o_rd_en;

        if (i_rst_n) begin
            if (e_rd) begin
                build_frame(i_tx_data, i_stop2, i_parity_en, i_parity_odd);
                m_s    = 0;
                m_busy = 1'b1;
            end else if (e_done) begin
                m_busy = 1'b0;
            end else if (m_busy && i_stick) begin
                m_s++;
            end
            m_armed = 1'b1;
        end
    endtask

    task automatic step();
        @(negedge i_clk);
        eval();
        @(posedge i_clk);
        #1;
        if (pop_pending && fifo_q.size() != 0) void'(fifo_q.pop_front());
        pop_pending = 1'b0;
        drive_stick();
        drive_fifo();
    endtask

    task automatic push(input logic [SD-1:0] d);
        fifo_q.push_back(d);
        drive_fifo();
    endtask

    task automatic wait_done(input int target, input int budget, input string tag);
        int k = 0;
        while (n_done < target && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(n_done >= target), 1);
    endtask

    task automatic wait_rd(input int target, input string tag);
        int k = 0;
        while (n_rd < target && k < 20) begin
            step();
            k++;
        end
        check(tag, 32'(n_rd >= target), 1);
    endtask

    initial begin
        int rd0, d0, k;
        i_rst_n = 1'b0; i_stick = 1'b0; i_tx_en = 1'b0;
        i_stop2 = 1'b0; i_parity_en = 1'b0; i_parity_odd = 1'b0;
        drive_fifo();
        #1;
        check("rst_serial", o_tx_serial, 1);
        check("rst_valid",  o_valid,     0);
        check("rst_rd_en",  o_rd_en,     0);
        check("rst_done",   o_tx_done,   0);
        repeat (3) step();
        i_rst_n = 1'b1;
        repeat (4) step();

        // Single 0x55 frame, one stop bit, no parity.
        rd0 = n_rd; d0 = n_done;
        push(8'h55);
        i_tx_en = 1'b1;
        wait_done(d0 + 1, 1200, "t035_timeout");
        i_tx_en = 1'b0;
        check("t035_rd_count", n_rd - rd0, 1);
        check("t035_sticks", sticks_at_done, 10 * OS);
        repeat (10) step();

        // Two 0x55 frames back-to-back, parity requested: even then odd.
        rd0 = n_rd; d0 = n_done;
        i_parity_en = 1'b1; i_parity_odd = 1'b0;
        push(8'h55); push(8'h55);
        i_tx_en = 1'b1;
        wait_rd(rd0 + 1, "t036_load");
        i_parity_odd = 1'b1;
        wait_done(d0 + 2, 2500, "t036_timeout");
        i_tx_en = 1'b0;
        check("t036_rd_count", n_rd - rd0, 2);
        check("t036_frame_clocks", last_done - prev_done, 4 * OS * (10 + int'(PAR_BUILD)));
        i_parity_en = 1'b0; i_parity_odd = 1'b0;
        repeat (10) step();

        // Two stop bits, i_stop2 toggled while the frame is on the line.
        d0 = n_done; rd0 = n_rd;
        i_stop2 = 1'b1;
        push(8'hA3);
        i_tx_en = 1'b1;
        wait_rd(rd0 + 1, "t037_load");
        k = 0;
        while (n_done == d0 && k < 1200) begin
            if (k % 37 == 0) i_stop2 = ~i_stop2;
            step();
            k++;
        end
        check("t037_timeout", 32'(n_done > d0), 1);
        check("t037_sticks", sticks_at_done, 11 * OS);
        i_tx_en = 1'b0; i_stop2 = 1'b0;
        repeat (10) step();

        // Three queued words with i_tx_en held: contiguous frames.
        rd0 = n_rd; d0 = n_done;
        push(8'h01); push(8'h02); push(8'h03);
        i_tx_en = 1'b1;
        wait_done(d0 + 3, 3000, "t038_timeout");
        repeat (5) step();
        check("t038_rd_count", n_rd - rd0, 3);
        check("t038_gap_clocks", last_done - prev_done, 10 * 4 * OS);
        check("t038_valid", o_valid, 0);

        // Asynchronous reset during data bit 3.
        push(8'h5A);
        k = 0;
        while (!(m_busy && m_s == 4 * OS + 5) && k < 600) begin
            step();
            k++;
        end
        check("t039_reach_bit3", 32'(m_busy && m_s == 4 * OS + 5), 1);
        d0 = n_done;
        #2;
        i_rst_n = 1'b0;
        #1;
        check("t039_serial", o_tx_serial, 1);
        check("t039_valid",  o_valid,     0);
        check("t039_rd_en",  o_rd_en,     0);
        check("t039_done",   o_tx_done,   0);
        m_busy = 1'b0; m_armed = 1'b0;
        push(8'h33);
        repeat (3) step();
        check("t039_no_done", n_done, d0);
        i_rst_n = 1'b1;
        wait_done(d0 + 1, 1200, "t039_after_reset");
        repeat (5) step();

        // Empty FIFO with transmit enabled: nothing may be popped.
        rd0 = n_rd;
        i_tx_en = 1'b1;
        repeat (1000) step();
        check("t040_rd_count", n_rd - rd0, 0);
        check("t040_line", o_tx_serial, 1);

        // Randomized traffic, stick timing and configuration.
        stick_rand = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(49) == 0) i_tx_en = ~i_tx_en;
            if (fifo_q.size() < 4 && $urandom_range(39) == 0) push(8'($urandom));
            if ($urandom_range(29) == 0) i_stop2      = 1'($urandom);
            if ($urandom_range(29) == 0) i_parity_en  = 1'($urandom);
            if ($urandom_range(29) == 0) i_parity_odd = 1'($urandom);
            step();
        end
        stick_rand = 1'b0;
        i_tx_en = 1'b1;
        k = 0;
        while ((fifo_q.size() != 0 || m_busy) && k < 8000) begin
            step();
            k++;
        end
        check("drain", 32'(fifo_q.size() == 0 && !m_busy), 1);
        i_tx_en = 1'b0;
        repeat (5) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
